// File: rtl/mnist_layer_sequencer.sv
// Phase sequencer for the two-layer MNIST accelerator: layer-1 pass, drain, layer-2 pass, drain, done.
// Optional busy-cycle counter enabled by defining SEQ_PERF_CNT_EN.
module mnist_layer_sequencer #(
    parameter int L1_LEN = 785,
    parameter int L2_LEN = 33,
    parameter int DRAIN  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] addr2,
    output logic              en1,
    output logic              en2,
    output logic              clr1,
    output logic              clr2,
    output logic              busy,
    output logic              done,
    output logic              irq,
    output logic [31:0]       cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        L1_RUN,
        L1_DRAIN,
        L2_RUN,
        L2_DRAIN,
        DONE
    } state_t;

    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = (DRAIN > 0) ? DW'(DRAIN - 1) : '0;
    localparam logic [ADDR_W-1:0] L1_LAST = ADDR_W'(L1_LEN - 1);
    localparam logic [ADDR_W-1:0] L2_LAST = ADDR_W'(L2_LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [ADDR_W-1:0] addr2_q, addr2_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              en1_q, en1_d;
    logic              en2_q, en2_d;
    logic              clr1_q, clr1_d;
    logic              clr2_q, clr2_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              irq_q, irq_d;
    logic              start;

    always_comb begin
        state_d = state_q;
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        drain_d = drain_q;
        en1_d   = en1_q;
        en2_d   = en2_q;
        clr1_d  = 1'b0;
        clr2_d  = 1'b0;
        done_d  = done_q;
        irq_d   = 1'b0;
        start   = 1'b0;

        if (abort) begin
            state_d = IDLE;
            addr1_d = '0;
            addr2_d = '0;
            en1_d   = 1'b0;
            en2_d   = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (go) begin
                        start   = 1'b1;
                        state_d = L1_RUN;
                        addr1_d = '0;
                        en1_d   = 1'b1;
                        clr1_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
                L1_RUN: begin
                    if (addr1_q == L1_LAST) begin
                        en1_d = 1'b0;
                        if (DRAIN == 0) begin
                            state_d = L2_RUN;
                            addr2_d = '0;
                            en2_d   = 1'b1;
                            clr2_d  = 1'b1;
                        end else begin
                            state_d = L1_DRAIN;
                            drain_d = DRAIN_LOAD;
                        end
                    end else begin
                        addr1_d = addr1_q + ADDR_W'(1);
                    end
                end
                L1_DRAIN: begin
                    if (drain_q == '0) begin
                        state_d = L2_RUN;
                        addr2_d = '0;
                        en2_d   = 1'b1;
                        clr2_d  = 1'b1;
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end
                L2_RUN: begin
                    if (addr2_q == L2_LAST) begin
                        en2_d = 1'b0;
                        if (DRAIN == 0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            irq_d   = 1'b1;
                        end else begin
                            state_d = L2_DRAIN;
                            drain_d = DRAIN_LOAD;
                        end
                    end else begin
                        addr2_d = addr2_q + ADDR_W'(1);
                    end
                end
                L2_DRAIN: begin
                    if (drain_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        irq_d   = 1'b1;
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    addr1_d = '0;
                    addr2_d = '0;
                    en1_d   = 1'b0;
                    en2_d   = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE) && (state_d != DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr1_q <= '0;
            addr2_q <= '0;
            drain_q <= '0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            clr1_q  <= 1'b0;
            clr2_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            drain_q <= drain_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
            clr1_q  <= clr1_d;
            clr2_q  <= clr2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
        end
    end

    assign addr1 = addr1_q;
    assign addr2 = addr2_q;
    assign en1   = en1_q;
    assign en2   = en2_q;
    assign clr1  = clr1_q;
    assign clr2  = clr2_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign irq   = irq_q;

`ifdef SEQ_PERF_CNT_EN
    // Counts cycles in which the registered busy flag is high; sticks at all-ones.
    logic [31:0] cycle_count_q, cycle_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (abort || start) begin
            cycle_count_d = '0;
        end else if (busy_q && (cycle_count_q != 32'hFFFF_FFFF)) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
`else
    logic unused_start;
    assign unused_start = start;
    assign cycle_count  = '0;
`endif

endmodule

// File: tb/tb_mnist_layer_sequencer.sv
// Directed self-checking bench for mnist_layer_sequencer: default build plus a DRAIN=0 small instance.
// Expected outputs come from a phase model driven by the edge index since go was sampled.
module tb_mnist_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        go, abort, go_s, abort_s;

    logic [31:0] addr1, addr2, cycle_count;
    logic        en1, en2, clr1, clr2, busy, done, irq;
    logic [31:0] addr1_s, addr2_s, cycle_count_s;
    logic        en1_s, en2_s, clr1_s, clr2_s, busy_s, done_s, irq_s;

    int compares = 0;
    int mismatches = 0;

    always #5 clk = ~clk;

    mnist_layer_sequencer dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort),
        .addr1(addr1), .addr2(addr2), .en1(en1), .en2(en2),
        .clr1(clr1), .clr2(clr2), .busy(busy), .done(done), .irq(irq),
        .cycle_count(cycle_count)
    );

    mnist_layer_sequencer #(.L1_LEN(4), .L2_LEN(3), .DRAIN(0), .ADDR_W(32)) dut_s (
        .clk(clk), .reset(reset), .go(go_s), .abort(abort_s),
        .addr1(addr1_s), .addr2(addr2_s), .en1(en1_s), .en2(en2_s),
        .clr1(clr1_s), .clr2(clr2_s), .busy(busy_s), .done(done_s), .irq(irq_s),
        .cycle_count(cycle_count_s)
    );

    logic [71:0] obs_m, obs_s;
    assign obs_m = {8'd0, addr1, addr2, en1, en2, clr1, clr2, busy, done, irq};
    assign obs_s = {8'd0, addr1_s, addr2_s, en1_s, en2_s, clr1_s, clr2_s, busy_s, done_s, irq_s};

    // Expected output vector k edges after the edge that sampled go.
    function automatic logic [71:0] model(int k, int l1, int l2, int d, int a2s);
        int a1 = 0, a2 = a2s;
        logic e1 = 0, e2 = 0, c1 = 0, c2 = 0, b = 0, dn = 0, iq = 0;
        int total = l1 + l2 + 2 * d;
        if (k < l1) begin
            a1 = k; e1 = 1; c1 = (k == 0); b = 1;
        end else if (k < l1 + d) begin
            a1 = l1 - 1; b = 1;
        end else if (k < l1 + d + l2) begin
            a1 = l1 - 1; a2 = k - l1 - d; e2 = 1; c2 = (a2 == 0); b = 1;
        end else if (k < total) begin
            a1 = l1 - 1; a2 = l2 - 1; b = 1;
        end else begin
            a1 = l1 - 1; a2 = l2 - 1; dn = 1; iq = (k == total);
        end
        return {8'd0, 32'(a1), 32'(a2), e1, e2, c1, c2, b, dn, iq};
    endfunction

    task automatic applyStimulus(input logic g, input logic a, input logic gs, input logic as_);
        go = g; abort = a; go_s = gs; abort_s = as_;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        compares++;
        assert (observed === expected)
        else begin
            mismatches++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    logic [71:0] exp_cc;

    initial begin
        go = 0; abort = 0; go_s = 0; abort_s = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_main", obs_m, 72'd0);
        checkOutput("reset_small", obs_s, 72'd0);
        checkOutput("reset_cc", {40'd0, cycle_count}, 72'd0);
        reset = 1'b0;

        for (int i = 0; i < 50; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("idle", obs_m, 72'd0);
        end

        // Small instance with go held: run ends at edge 7, go still high restarts at edge 8.
        applyStimulus(0, 0, 1, 0);
        for (int k = 0; k <= 16; k++) begin
            if (k <= 7) checkOutput("small_run1", obs_s, model(k, 4, 3, 0, 0));
            else        checkOutput("small_run2", obs_s, model(k - 8, 4, 3, 0, 2));
            applyStimulus(0, 0, (k < 14), 0);
        end

        // Full default run with a go pulse while busy at addr1=100.
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k <= 824; k++) begin
            checkOutput($sformatf("full_run_k%0d", k), obs_m, model(k, 785, 33, 2, 0));
            if (k < 824) applyStimulus((k == 100), 0, 0, 0);
        end
`ifdef SEQ_PERF_CNT_EN
        exp_cc = 72'd822;
`else
        exp_cc = 72'd0;
`endif
        checkOutput("cycle_count_done", {40'd0, cycle_count}, exp_cc);

        // Restart from DONE, then abort when addr2 reaches 10.
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k <= 797; k++) begin
            checkOutput("restart_run", obs_m, model(k, 785, 33, 2, 32));
            if (k < 797) applyStimulus(0, 0, 0, 0);
        end
        checkOutput("abort_point_addr2", {40'd0, addr2}, 72'd10);
        applyStimulus(0, 1, 0, 0);
        checkOutput("abort_clear", obs_m, 72'd0);
        checkOutput("abort_cc", {40'd0, cycle_count}, 72'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("abort_no_irq", obs_m, 72'd0);

        applyStimulus(1, 1, 0, 0);
        checkOutput("go_and_abort", obs_m, 72'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("go_and_abort_after", obs_m, 72'd0);

        // Asynchronous reset in the middle of the layer-1 pass.
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < 300; k++) applyStimulus(0, 0, 0, 0);
        checkOutput("pre_reset_addr1", obs_m, model(300, 785, 33, 2, 0));
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_clear", obs_m, 72'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkOutput("post_reset_idle", obs_m, 72'd0);
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("fresh_run", obs_m, model(k, 785, 33, 2, 0));
            applyStimulus(0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule

// File: doc/mnist_layer_sequencer.md
Name: mnist_layer_sequencer

Overview:
Sequences the two-layer MNIST accelerator: it runs the layer-1 systolic pass, then the layer-2 pass, then reports completion to the PicoRV32 peripheral interface. Pass lengths are fixed by parameters, so no sentinel words are needed in the weight memories. The block drives the weight/input read addresses, the per-layer enables and accumulator clears, and the busy/done/irq status. It supports CPU-initiated start, restart and abort.

Parameters:
L1_LEN, 785, layer-1 inner-product length in cycles (must be >= 1)
L2_LEN, 33, layer-2 inner-product length in cycles (must be >= 1)
DRAIN, 2, pipeline drain cycles after each pass before the next phase (0 allowed)
ADDR_W, 32, width of the address counters

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
go  in  1  start request from the CPU register interface; level sampled each clk
abort  in  1  abandon the current run; level sampled each clk
addr1  out  ADDR_W  layer-1 weight/input read address
addr2  out  ADDR_W  layer-2 weight read address
en1  out  1  layer-1 systolic array enable
en2  out  1  layer-2 systolic array enable
clr1  out  1  layer-1 accumulator clear, one-cycle pulse
clr2  out  1  layer-2 accumulator clear, one-cycle pulse
busy  out  1  high in any state except IDLE and DONE
done  out  1  result valid; held until the next accepted go or an abort
irq  out  1  one-cycle pulse on entry to DONE
cycle_count  out  32  busy-cycle counter (see Optional Feature)

Behaviour:
- All outputs are registered. Reset (async) forces: state=IDLE, addr1=addr2=0, and en1, en2, clr1, clr2, busy, done, irq, cycle_count all 0.
- States: IDLE, L1_RUN, L1_DRAIN, L2_RUN, L2_DRAIN, DONE.
- IDLE/DONE with go=1 and abort=0: next edge enters L1_RUN with addr1=0, en1=1, clr1=1, busy=1, done=0.
- L1_RUN: lasts exactly L1_LEN cycles. addr1 steps 0..L1_LEN-1, incrementing by 1 per cycle. clr1 is high only in the first cycle. When addr1==L1_LEN-1, the next state is L1_DRAIN, or L2_RUN if DRAIN=0. On exit, en1=0 and addr1 holds L1_LEN-1.
- L1_DRAIN: lasts exactly DRAIN cycles, using an internal down-counter. en1 and en2 are both 0.
- L2_RUN: mirrors L1_RUN, using addr2, en2, clr2 and L2_LEN. The next state is L2_DRAIN, or DONE if DRAIN=0.
- L2_DRAIN: lasts DRAIN cycles, then goes to DONE.
- DONE entry: done=1, busy=0, irq=1 for that single cycle. addr1 and addr2 hold their last values.
- Latency: done rises on the (L1_LEN+L2_LEN+2*DRAIN)th rising edge after the edge that samples go.
- go while busy: ignored, with no effect on state or counters.
- go held high continuously: the first sample starts a run. After DONE, the next sample of go=1 restarts immediately, and done is low for the whole restarted run.
- abort=1 in any state: next edge enters IDLE. addr1=addr2=0, en/clr/done/irq=0. Abort takes priority over go in the same cycle.
- Address arithmetic: unsigned ADDR_W-bit values; they never wrap because the terminal compare stops them.
- Reset mid-run: immediate return to the reset values, with no irq.

Optional Feature:
SEQ_PERF_CNT_EN
- Defined: cycle_count clears to 0 on each accepted go and increments on every cycle with busy=1. It holds its value in DONE and clears on abort. It saturates at 32'hFFFFFFFF.
- Undefined: cycle_count is tied to 0 and no counter logic is present.

Test Plan:
- Reset then idle (defaults): hold go=0 for 50 cycles -> busy=0, done=0, en1=en2=0, addr1=addr2=0 throughout.
- Full run (defaults): pulse go for 1 cycle -> en1 high for 785 cycles, addr1 0..784; clr1 high in the first cycle only; 2 idle-enable cycles; en2 high for 33 cycles, addr2 0..32, clr2 in its first cycle; 2 drain cycles; done rises 822 edges after the go sample with a 1-cycle irq. With SEQ_PERF_CNT_EN, cycle_count=822.
- go during a run: pulse go at addr1=100 -> no change; done still rises at the 822nd edge.
- Abort: assert abort at addr2=10 -> next edge busy=0, en2=0, addr1=addr2=0, and no irq or done. Assert go and abort together from IDLE -> the block stays in IDLE.
- DRAIN=0, L1_LEN=4, L2_LEN=3: pulse go -> en1 for 4 cycles, then en2 directly for 3 cycles; done at the 7th edge.
- Async reset during L1_RUN at addr1=300: assert reset mid-cycle -> outputs clear before the next clk edge. After release, go starts a fresh run from addr1=0.
